div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a divide; asserted by EX stage for DIV/DIVU (the decoder's hilo_we=11 divide ops).
REQ-005 Port: signed_div  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 Port: a  input  DATA_W  dividend (rs).
REQ-007 Port: b  input  DATA_W  divisor (rt).
REQ-008 Port: annul  input  1  flush/exception; cancels any operation in progress.
REQ-009 Port: busy  output  1  pipeline stall request.
REQ-010 Port: ready  output  1  one-cycle pulse, result valid.
REQ-011 Port: result  output  2*DATA_W  {remainder -> HI, quotient -> LO}.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, DIV_ZERO, ON, END.
REQ-013 IDLE: start=1 and annul=0 SHALL go to DIV_ZERO if b==0, else to ON; operands, signed_div and sign flags latched on that edge.
REQ-014 The latch edge SHALL store |a| and |b| (two's-complement negate when signed_div=1 and MSB=1), plus the quotient sign a[MSB]^b[MSB] and the remainder sign a[MSB].
REQ-015 ON SHALL run one restoring shift-subtract iteration per cycle for exactly DATA_W cycles, counted 0..DATA_W-1, then go to END.
REQ-016 DIV_ZERO SHALL last one cycle, load result = 0, then go to END.
REQ-017 END SHALL last one cycle: ready=1, then unconditionally IDLE.
REQ-018 Signed fix-up SHALL apply on entry to END.
  - quotient negated if the quotient sign = 1.
  - remainder negated if the remainder sign = 1.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0 with no trap.
REQ-019 busy SHALL be combinational: (state==IDLE & start & ~annul) | state==ON | state==DIV_ZERO; busy=0 in END so the stalled instruction advances with result.
REQ-020 Timing for a start accepted in cycle C0:
  - normal divide: busy high C0..C32, ready high in C33 only.
  - divide by zero: busy high C0..C1, ready high in C2.
REQ-021 The result register SHALL hold its value from END until the next END; ready alone qualifies it.
REQ-022 start while not IDLE SHALL be ignored; no queuing.
REQ-023 annul in any state SHALL force IDLE on the next edge with no ready pulse; result is unchanged.
REQ-024 annul and start together in IDLE SHALL not start an operation.

Reset
REQ-025 resetn=0 SHALL immediately force state=IDLE, counter=0, result=0, ready=0, busy=0 and clear all operand/sign registers, regardless of clk or state.
REQ-026 After resetn deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-027 State encodings (IDLE/DIV_ZERO/ON/END) and DIV_W=32 SHALL live in the shared defines.vh alongside the EXE_* opcode constants.
REQ-028 The block SHALL be a single module with no sub-module; the iteration datapath is a (DATA_W+1)-bit subtractor plus 2*DATA_W+1-bit shift register.

Verification
REQ-029 DIVU a=100, b=7 -> busy C0..C32, ready only in C33, result HI=2, LO=14.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, ready in C33.
REQ-032 a=5, b=0 (either signedness) -> ready in C2, result=0, busy low from C2.
REQ-033 annul asserted in C10 of a divide -> IDLE at C11, no ready; start in C11 -> a fresh 34-cycle divide with correct result.
REQ-034 resetn low in C15 of a divide -> busy, ready and result 0 asynchronously; start held high during reset does not start an operation.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared divider constants: FSM state encodings, default width and EX-stage divide opcodes.
package div_unit_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_DIV_ZERO = 2'b01;
  localparam logic [1:0] ST_ON       = 2'b10;
  localparam logic [1:0] ST_END      = 2'b11;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU. It produces one quotient bit per cycle and raises
// busy to stall the pipeline. The result is {remainder, quotient} and is qualified by ready.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                annul,
  output logic                busy,
  output logic                ready,
  output logic [2*DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_divisor;
  logic [2*DATA_W:0]   r_acc;
  logic                r_signed;
  logic                r_qsign;
  logic                r_rsign;
  logic [2*DATA_W-1:0] r_result;

  logic                w_accept;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_a_abs;
  logic [DATA_W-1:0]   w_b_abs;
  logic [2*DATA_W:0]   w_shift;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W:0]   w_acc_nxt;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_quot_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  assign w_accept = (r_state == ST_IDLE) & start & ~annul;
  assign w_a_neg  = signed_div & a[DATA_W-1];
  assign w_b_neg  = signed_div & b[DATA_W-1];
  assign w_a_abs  = w_a_neg ? -a : a;
  assign w_b_abs  = w_b_neg ? -b : b;

  // Partial remainder in the upper DATA_W+1 bits, dividend/quotient bits shifting through the lower half.
  assign w_shift    = r_acc << 1;
  assign w_diff     = w_shift[2*DATA_W:DATA_W] - {1'b0, r_divisor};
  assign w_acc_nxt  = w_diff[DATA_W] ? w_shift : {w_diff, w_shift[DATA_W-1:1], 1'b1};
  assign w_quot     = w_acc_nxt[DATA_W-1:0];
  assign w_rem      = w_acc_nxt[2*DATA_W-1:DATA_W];
  assign w_quot_fix = (r_signed & r_qsign) ? -w_quot : w_quot;
  assign w_rem_fix  = (r_signed & r_rsign) ? -w_rem : w_rem;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_state_nxt = (b == '0) ? ST_DIV_ZERO : ST_ON;
      ST_DIV_ZERO: w_state_nxt = ST_END;
      ST_ON:       if (r_cnt == LAST_CNT) w_state_nxt = ST_END;
      ST_END:      w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (annul) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_acc     <= '0;
      r_signed  <= 1'b0;
      r_qsign   <= 1'b0;
      r_rsign   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc     <= {{(DATA_W+1){1'b0}}, w_a_abs};
        r_divisor <= w_b_abs;
        r_cnt     <= '0;
        r_signed  <= signed_div;
        r_qsign   <= signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
        r_rsign   <= signed_div & a[DATA_W-1];
      end
      if ((r_state == ST_ON) && !annul) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) r_result <= {w_rem_fix, w_quot_fix};
      end
      if ((r_state == ST_DIV_ZERO) && !annul) r_result <= '0;
    end
  end

  // Gated by resetn so a start held high through reset never stalls the pipeline.
  assign busy   = resetn & (w_accept | (r_state == ST_ON) | (r_state == ST_DIV_ZERO));
  assign ready  = (r_state == ST_END);
  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: random and directed divides against an arithmetic reference.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk;
  int          n_fail;
  int          cyc;
  logic [63:0] last_res;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .busy       (busy),
    .ready      (ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected results outstanding, required 0", sb_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input bit sd, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) return 64'd0;
    if (sd) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  always @(negedge clk) begin
    if (resetn && ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called 1 time unit after a rising edge with the DUT idle; returns at the same phase, DUT idle again.
  task automatic run_op(input bit sd, input logic [31:0] x, input logic [31:0] y);
    int   lat;
    exp_t e;
    start      = 1'b1;
    signed_div = sd;
    a          = x;
    b          = y;
    lat        = (y == 32'd0) ? 2 : 33;
    e.res      = model(sd, x, y);
    e.cyc      = cyc + lat;
    sb_q.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("busy", 64'(busy), 64'(k < lat));
      if (k < lat) check("no_early_ready", 64'(ready), 64'd0);
      @(posedge clk);
      #1;
      if (k == 0) start = 1'b0;
    end
    last_res = e.res;
    check("result_hold", result, last_res);
  endtask

  task automatic run_annul(input logic [31:0] x, input logic [31:0] y, input int ann_k);
    start      = 1'b1;
    signed_div = 1'b0;
    a          = x;
    b          = y;
    for (int k = 0; k < ann_k; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    annul = 1'b1;
    @(negedge clk);
    check("busy_during_annul", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("busy_after_annul", 64'(busy), 64'd0);
    check("result_kept_after_annul", result, last_res);
  endtask

  task automatic run_reset(input logic [31:0] x, input logic [31:0] y, input int rst_k);
    start      = 1'b1;
    signed_div = 1'b0;
    a          = x;
    b          = y;
    for (int k = 0; k < rst_k; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    resetn = 1'b0;
    start  = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    last_res = 64'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_busy_held", 64'(busy), 64'd0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    last_res   = 64'd0;
    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    annul      = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'd5, 32'd0);
    run_op(1'b1, 32'd5, 32'd0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);

    run_annul(32'd1000, 32'd3, 10);
    run_op(1'b0, 32'd1000, 32'd3);

    run_reset(32'd12345, 32'd67, 15);
    run_op(1'b0, 32'd12345, 32'd67);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      int          sel;
      sel = $urandom_range(0, 7);
      x   = $urandom;
      y   = $urandom;
      case (sel)
        0:       y = 32'd0;
        1:       y = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF;
        2:       y = $urandom_range(1, 15);
        3:       x = $urandom_range(0, 50);
        default: ;
      endcase
      run_op($urandom_range(0, 1) == 1, x, y);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
